// File: rtl/ssd_arbiter.sv
// ssd_arbiter: time-shares the seven-segment display between three requesters.
// Ownership is granted round-robin with a minimum dwell; the owner's 32-bit word
// is registered onto the value bus that feeds the display manager.
//
// Handshake: req[i] is a level request held high while requester i wants the
// display; grant is a registered one-hot acknowledgement (or zero when idle),
// and value/busy are registered alongside it, valid after the same edge.
//
// Debug: ssd_arbiter_oport_state exposes the FSM state (0 = IDLE, 1 = HOLD,
// 2 = OPEN) for checkers.
module ssd_arbiter #(
    parameter logic [31:0] HOLD       = 32'd100_000_000,
    parameter logic [31:0] IDLE_VALUE = 32'h0000_0000
) (
    input  logic        ssd_arbiter_clk,
    input  logic        ssd_arbiter_rst_n,
    input  logic [2:0]  ssd_arbiter_port_req,
    input  logic [31:0] ssd_arbiter_port_data0,
    input  logic [31:0] ssd_arbiter_port_data1,
    input  logic [31:0] ssd_arbiter_port_data2,
    output logic [2:0]  ssd_arbiter_oport_grant,
    output logic [31:0] ssd_arbiter_oport_value,
    output logic        ssd_arbiter_oport_busy,
    output logic [1:0]  ssd_arbiter_oport_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OPEN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  last;

    logic [2:0]  cand;
    logic        owner_req;
    logic [1:0]  rr_start;
    logic [2:0]  rr_pos;
    logic        rr_found;
    logic [1:0]  rr_idx;
    logic [31:0] rr_data;
    logic [31:0] owner_data;
    logic        take;

    // Candidate search: first non-owner requester in order last+1, last+2, last+3 (mod 3).
    always_comb begin
        cand      = ssd_arbiter_port_req & ~ssd_arbiter_oport_grant;
        owner_req = |(ssd_arbiter_port_req & ssd_arbiter_oport_grant);
        rr_start  = (last == 2'd2) ? 2'd0 : last + 2'd1;
        rr_pos    = 3'd0;
        rr_found  = 1'b0;
        rr_idx    = 2'd0;
        // Walk the order backwards so the earliest hit is the one that sticks.
        for (int i = 2; i >= 0; i--) begin
            rr_pos = {1'b0, rr_start} + 3'(i);
            if (rr_pos > 3'd2) begin
                rr_pos = rr_pos - 3'd3;
            end
            if (cand[rr_pos[1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_pos[1:0];
            end
        end
    end

    // Data muxes for the candidate winner and for the current owner (last == owner while owned).
    always_comb begin
        case (rr_idx)
            2'd0:    rr_data = ssd_arbiter_port_data0;
            2'd1:    rr_data = ssd_arbiter_port_data1;
            default: rr_data = ssd_arbiter_port_data2;
        endcase
        case (last)
            2'd0:    owner_data = ssd_arbiter_port_data0;
            2'd1:    owner_data = ssd_arbiter_port_data1;
            default: owner_data = ssd_arbiter_port_data2;
        endcase
    end

    // A new grant happens from IDLE, on release during HOLD, or on any competing request in OPEN.
    always_comb begin
        take = 1'b0;
        case (state)
            ST_IDLE: take = rr_found;
            ST_HOLD: take = rr_found && !owner_req;
            ST_OPEN: take = rr_found;
            default: take = 1'b0;
        endcase
    end

    // Arbiter FSM with registered grant, value and busy.
    always_ff @(posedge ssd_arbiter_clk or negedge ssd_arbiter_rst_n) begin
        if (!ssd_arbiter_rst_n) begin
            state                   <= ST_IDLE;
            cnt                     <= 32'd0;
            last                    <= 2'd2;
            ssd_arbiter_oport_grant <= 3'b000;
            ssd_arbiter_oport_value <= IDLE_VALUE;
            ssd_arbiter_oport_busy  <= 1'b0;
        end else if (take) begin
            state                   <= ST_HOLD;
            cnt                     <= HOLD - 32'd1;
            last                    <= rr_idx;
            ssd_arbiter_oport_grant <= 3'b001 << rr_idx;
            ssd_arbiter_oport_value <= rr_data;
            ssd_arbiter_oport_busy  <= 1'b1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (!owner_req) begin
                        state                   <= ST_IDLE;
                        ssd_arbiter_oport_grant <= 3'b000;
                        ssd_arbiter_oport_value <= IDLE_VALUE;
                        ssd_arbiter_oport_busy  <= 1'b0;
                    end else if (cnt == 32'd0) begin
                        state                   <= ST_OPEN;
                        ssd_arbiter_oport_value <= owner_data;
                        ssd_arbiter_oport_busy  <= 1'b0;
                    end else begin
                        cnt                     <= cnt - 32'd1;
                        ssd_arbiter_oport_value <= owner_data;
                    end
                end
                ST_OPEN: begin
                    if (!owner_req) begin
                        state                   <= ST_IDLE;
                        ssd_arbiter_oport_grant <= 3'b000;
                        ssd_arbiter_oport_value <= IDLE_VALUE;
                        ssd_arbiter_oport_busy  <= 1'b0;
                    end else begin
                        ssd_arbiter_oport_value <= owner_data;
                    end
                end
                default: begin
                    // IDLE with no request, or an unreachable encoding.
                    state                   <= ST_IDLE;
                    ssd_arbiter_oport_grant <= 3'b000;
                    ssd_arbiter_oport_value <= IDLE_VALUE;
                    ssd_arbiter_oport_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ssd_arbiter_oport_state = state;

endmodule

// File: tb/tb_ssd_arbiter.sv
// Bench for ssd_arbiter: three instances with HOLD = 4, 2 and 1 share the same
// stimulus and are compared every cycle against a behavioural model, plus a
// vector table and hand-written corner sequences.
module tb_ssd_arbiter;

  localparam logic [2:0][31:0] HOLDS = {32'd1, 32'd2, 32'd4};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        req;
  logic [31:0]       d0, d1, d2;
  logic [2:0][2:0]   grant_w;
  logic [2:0][31:0]  value_w;
  logic [2:0]        busy_w;
  logic [2:0][1:0]   state_w;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    ssd_arbiter #(
      .HOLD       (HOLDS[gi]),
      .IDLE_VALUE (32'h0000_0000)
    ) u_dut (
      .ssd_arbiter_clk         (clk),
      .ssd_arbiter_rst_n       (rst_n),
      .ssd_arbiter_port_req    (req),
      .ssd_arbiter_port_data0  (d0),
      .ssd_arbiter_port_data1  (d1),
      .ssd_arbiter_port_data2  (d2),
      .ssd_arbiter_oport_grant (grant_w[gi]),
      .ssd_arbiter_oport_value (value_w[gi]),
      .ssd_arbiter_oport_busy  (busy_w[gi]),
      .ssd_arbiter_oport_state (state_w[gi])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural reference model: owner index, previous owner, edges since grant
  int m_owner[3];
  int m_last[3];
  int m_since[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_last[i]  = 2;
      m_since[i] = 0;
    end
  endtask

  function automatic int pick(input logic [2:0] c, input int from);
    for (int k = 1; k <= 3; k++) begin
      int j;
      j = (from + k) % 3;
      if (c[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] data_of(input int k);
    case (k)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  task automatic model_grant(input int i, input int n);
    m_owner[i] = n;
    m_last[i]  = n;
    m_since[i] = 0;
  endtask

  task automatic model_step();
    logic [2:0] others;
    int n;
    int hold;
    for (int i = 0; i < 3; i++) begin
      hold = int'(HOLDS[i]);
      if (m_owner[i] < 0) begin
        n = pick(req, m_last[i]);
        if (n >= 0) model_grant(i, n);
      end else begin
        others = req & ~(3'b001 << m_owner[i]);
        if (!req[m_owner[i]]) begin
          n = pick(others, m_last[i]);
          if (n >= 0) model_grant(i, n);
          else m_owner[i] = -1;
        end else if (m_since[i] >= hold && others != 3'b000) begin
          model_grant(i, pick(others, m_last[i]));
        end else if (m_since[i] < hold) begin
          m_since[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic [2:0]  eg;
      logic [31:0] ev;
      logic        eb;
      eg = (m_owner[i] < 0) ? 3'b000 : (3'b001 << m_owner[i]);
      ev = (m_owner[i] < 0) ? 32'h0 : data_of(m_owner[i]);
      eb = (m_owner[i] >= 0) && (m_since[i] < int'(HOLDS[i]));
      check($sformatf("model_grant_h%0d", HOLDS[i]), 32'(grant_w[i]), 32'(eg));
      check($sformatf("model_value_h%0d", HOLDS[i]), value_w[i], ev);
      check($sformatf("model_busy_h%0d", HOLDS[i]), 32'(busy_w[i]), 32'(eb));
    end
  endtask

  // driver: one clock edge, model update on the edge, compare 1 time unit later
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_grant"}, 32'(grant_w[i]), 32'h0);
      check({tag, "_value"}, value_w[i], 32'h0);
      check({tag, "_busy"}, 32'(busy_w[i]), 32'h0);
      check({tag, "_state"}, 32'(state_w[i]), 32'h0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] value_for(input logic [2:0] g);
    case (g)
      3'b001:  return d0;
      3'b010:  return d1;
      3'b100:  return d2;
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [2:0] req;
    logic [2:0] exp_grant;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // dwell, early release, handover vectors for the HOLD = 4 instance
    vecs[0]  = '{3'b001, 3'b001, 1'b1};
    vecs[1]  = '{3'b011, 3'b001, 1'b1};
    vecs[2]  = '{3'b011, 3'b001, 1'b1};
    vecs[3]  = '{3'b011, 3'b001, 1'b1};
    vecs[4]  = '{3'b011, 3'b001, 1'b0};
    vecs[5]  = '{3'b011, 3'b010, 1'b1};
    vecs[6]  = '{3'b010, 3'b010, 1'b1};
    vecs[7]  = '{3'b000, 3'b000, 1'b0};
    vecs[8]  = '{3'b100, 3'b100, 1'b1};
    vecs[9]  = '{3'b000, 3'b000, 1'b0};
    vecs[10] = '{3'b001, 3'b001, 1'b1};
    vecs[11] = '{3'b000, 3'b000, 1'b0};
    vecs[12] = '{3'b110, 3'b010, 1'b1};
    vecs[13] = '{3'b100, 3'b100, 1'b1};

    // reset values with all requests high
    rst_n = 1'b0;
    req   = 3'b111;
    d0 = 32'hAAAA_AAAA; d1 = 32'hAAAA_AAAA; d2 = 32'hAAAA_AAAA;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("first_grant", 32'(grant_w[0]), 32'h1);
    check("first_value", value_w[0], 32'hAAAA_AAAA);

    // table-driven vectors
    d0 = 32'hA0A0_A0A0; d1 = 32'hB1B1_B1B1; d2 = 32'hC2C2_C2C2;
    req = 3'b000;
    do_reset();
    for (int v = 0; v < 14; v++) begin
      req = vecs[v].req;
      cycle();
      check($sformatf("vec%0d_grant", v), 32'(grant_w[0]), 32'(vecs[v].exp_grant));
      check($sformatf("vec%0d_busy", v), 32'(busy_w[0]), 32'(vecs[v].exp_busy));
      check($sformatf("vec%0d_value", v), value_w[0], value_for(vecs[v].exp_grant));
    end

    // round robin on HOLD = 2: 001, 010, 100, 001 ... three cycles each
    req = 3'b111;
    do_reset();
    for (int c = 0; c < 20; c++) exp_q.push_back(3'b001 << ((c / 3) % 3));
    for (int c = 0; c < 20; c++) begin
      logic [2:0] eg;
      cycle();
      eg = exp_q.pop_front();
      check($sformatf("rr_grant_c%0d", c), 32'(grant_w[1]), 32'(eg));
      check($sformatf("rr_busy_c%0d", c), 32'(busy_w[1]), 32'((c % 3) != 2));
    end

    // live data tracking with requester 1 owning
    req = 3'b000;
    do_reset();
    req = 3'b010;
    d0 = 32'h1111_1111; d1 = 32'h1234_5678; d2 = 32'h2222_2222;
    cycle();
    check("live_first", value_w[0], 32'h1234_5678);
    cycle();
    d1 = 32'hDEAD_BEEF;
    cycle();
    check("live_update", value_w[0], 32'hDEAD_BEEF);
    for (int c = 0; c < 6; c++) begin
      d0 = $urandom;
      d2 = $urandom;
      cycle();
      check("live_owner_only", value_w[0], 32'hDEAD_BEEF);
    end

    // reset asserted mid-HOLD, between edges
    req = 3'b000;
    do_reset();
    req = 3'b010;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    req = 3'b101;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("midreset_regrant", 32'(grant_w[0]), 32'h1);

    // randomized traffic against the model
    req = 3'b000;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 3) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 2) d0 = $urandom;
      if ($urandom_range(0, 9) < 2) d1 = $urandom;
      if ($urandom_range(0, 9) < 2) d2 = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_arbiter.md
# ssd_arbiter

Time-shares the 8-digit seven-segment display between three requesters: free-running counters, debug registers and user input. It grants display ownership with a minimum dwell time and round-robin fairness. The granted requester's 32-bit word (eight hex nibbles) is registered onto a single output bus. That bus feeds the display manager's 32-bit value input.

## Interface
- HOLD, 100_000_000, minimum dwell in clock cycles before an owner can be preempted (1 s at 100 MHz); legal range 1 to 2^32-1.
- IDLE_VALUE, 32'h0000_0000, word driven on the value output when no requester owns the display.
- ssd_arbiter_clk  input  1  system clock; all state updates on rising edge.
- ssd_arbiter_rst_n  input  1  reset, asynchronous and active-low.
- ssd_arbiter_port_req  input  3  request per requester; bit i is held high while requester i wants the display.
- ssd_arbiter_port_data0  input  32  display word of requester 0.
- ssd_arbiter_port_data1  input  32  display word of requester 1.
- ssd_arbiter_port_data2  input  32  display word of requester 2.
- ssd_arbiter_oport_grant  output  3  one-hot current owner, or 3'b000 when idle; registered.
- ssd_arbiter_oport_value  output  32  word to the display manager; registered.
- ssd_arbiter_oport_busy  output  1  high while in HOLD, i.e. the owner cannot be preempted; registered.

## Operation
- **States.**
  - IDLE: no owner.
  - HOLD: owner present, dwell counter running.
  - OPEN: owner present, dwell expired, preemptable.
- **Round-robin pointer.** `last` (2 bits) records the most recent owner. The search order starts at last+1 mod 3. The reset value of `last` is 2, so requester 0 wins first.
- **IDLE.**
  - If any req bit is high, grant the first requester in search order, load counter = HOLD-1, go to HOLD.
  - Otherwise stay in IDLE.
- **HOLD.**
  - If the owner's req is low: release. If another req is high, grant the next in search order (starting after the owner), reload the counter, stay in HOLD. Otherwise go to IDLE.
  - If the owner's req is high and counter == 0: go to OPEN.
  - Otherwise decrement the counter. Other requesters are ignored.
- **OPEN.**
  - If any non-owner req is high: switch to the first non-owner in search order, reload counter = HOLD-1, go to HOLD. This applies whether or not the owner's req is still high.
  - Else if the owner's req is low: go to IDLE.
  - Else stay in OPEN.
- **On every grant change,** `last` updates to the new owner.
- **Value output.**
  - Every cycle, the value register loads the data of the owner selected for the next cycle.
  - Live data changes from the owner propagate with 1-cycle latency.
  - In IDLE the value register loads IDLE_VALUE.
- Grant is always one-hot or zero. Two bits are never simultaneously high.
- Busy = 1 exactly when the state is HOLD.
- **Counter.** 32-bit, unsigned. It never wraps: the decrement happens only while nonzero.

## Timing
- **Reset (asynchronous assert, synchronous release).** State = IDLE, grant = 3'b000, value = IDLE_VALUE, busy = 0, counter = 0, last = 2.
- **Reset mid-operation.** The same values appear immediately on assert, without waiting for a clock edge. The arbiter resumes from IDLE after release.
- **Grant latency.** A req sampled high at edge k in IDLE gives grant and value valid after edge k. Busy = 1 from the same edge.
- **Dwell.** A grant issued at edge k is preemptable (OPEN) after edge k+HOLD. The earliest switch to another requester is edge k+HOLD+1.
- **Release latency.** The owner dropping req at edge k clears or moves the grant after edge k. This holds in both HOLD and OPEN.
- **Simultaneous events.** The owner dropping req on the same edge a new req rises gives a direct handover. There is no IDLE cycle between owners.
- **HOLD = 1.** The owner goes to OPEN on the edge after the grant.
- Inputs are synchronous to ssd_arbiter_clk; no synchronizers are inside the block.

## Test plan
- **Reset values.** Apply reset with req = 3'b111 and data = 32'hAAAA_AAAA. Required: grant = 000, value = 32'h0000_0000, busy = 0. Then release reset; on the first edge, grant = 001 and value = data0.
- **Dwell enforcement (HOLD = 4).** Requester 0 is granted at edge k, then req1 rises at k+1. Required: grant stays 001 through edge k+3, OPEN at k+4, grant = 010 at k+5. Busy is high for 4 cycles after each grant.
- **Early release.** Requester 2 is granted, then drops req at the second cycle with no other req pending. Required: grant = 000 and value = IDLE_VALUE after that edge. The next req0 is granted first because last = 2.
- **Round-robin fairness.** Hold req = 111 for 20 cycles (HOLD = 2). Required: grant sequence 001, 010, 100, 001, each lasting 3 cycles, with no idle gaps.
- **Live data tracking.** With requester 1 owning, change data1 from 32'h1234_5678 to 32'hDEAD_BEEF at edge k. Required: value = 32'hDEAD_BEEF after edge k+1. Data from requesters 0 and 2 never appears while requester 1 owns.
- **Reset mid-HOLD.** Assert rst_n low between edges while in HOLD. Required: outputs reach reset values immediately. After release, only current req bits are used to arbitrate, with the search order starting at requester 0.
